// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port selects, memory depth.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEPTH = 16;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner: on a tie the port that was not granted last wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic reqA,
  input  logic reqB,
  input  logic lastGrant,
  output logic anyReq,
  output logic winner
);

  always_comb begin
    anyReq = reqA | reqB;
    winner = SEL_A;
    if (reqA && reqB) begin
      winner = (lastGrant == SEL_A) ? SEL_B : SEL_A;
    end else if (reqB) begin
      winner = SEL_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 16-word data memory.
// state  | meaning
// IDLE   | no access in flight, waiting for a request
// ACCESS | strobes driven for the latched request (one cycle)
// RESP   | ack/err to the granted port; may latch the other port back-to-back
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = dmem_arbiter_pkg::DEPTH
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              a_stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arbState_e         state, stateNext;
  logic              sel, lastGrant, weQ, errPending;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              reqAElig, reqBElig, anyReq, winner, canLatch, inRange;

  // The port being acked in RESP must not win again in the same cycle.
  assign reqAElig = a_req & ~(state == RESP && sel == SEL_A);
  assign reqBElig = b_req & ~(state == RESP && sel == SEL_B);

  rr_pick2 u_pick (
    .reqA     (reqAElig),
    .reqB     (reqBElig),
    .lastGrant(lastGrant),
    .anyReq   (anyReq),
    .winner   (winner)
  );

  assign canLatch = (state == IDLE || state == RESP) && anyReq;
  assign inRange  = addrQ < ADDR_W'(DEPTH);

  always_comb begin
    stateNext = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:   if (anyReq) stateNext = ACCESS;
      ACCESS: begin
        stateNext = RESP;
        if (inRange) begin
          mem_addr  = addrQ;
          mem_wdata = wdataQ;
          mem_write = weQ;
          mem_read  = ~weQ;
        end
      end
      RESP:    stateNext = anyReq ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lastGrant  <= SEL_B;
      sel        <= SEL_A;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      errPending <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state <= stateNext;
      if (canLatch) begin
        sel    <= winner;
        weQ    <= (winner == SEL_B) ? b_we    : a_we;
        addrQ  <= (winner == SEL_B) ? b_addr  : a_addr;
        wdataQ <= (winner == SEL_B) ? b_wdata : a_wdata;
      end
      if (state == ACCESS) begin
        errPending <= ~inRange;
        lastGrant  <= sel;
        // Writes and out-of-range accesses return zero rather than stale data.
        if (sel == SEL_A) a_rdata <= (inRange && !weQ) ? mem_rdata : '0;
        else              b_rdata <= (inRange && !weQ) ? mem_rdata : '0;
      end
    end
  end

  assign a_ack   = (state == RESP) && (sel == SEL_A);
  assign b_ack   = (state == RESP) && (sel == SEL_B);
  assign a_err   = a_ack & errPending;
  assign b_err   = b_ack & errPending;
  assign a_stall = a_req & ~a_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a sequential memory model predicts each ack; a monitor checks them.
module tb_dmem_arbiter;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, a_stall, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock_in = ~clock_in;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(16)) dut (
    .clock_in(clock_in), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stand-in for data_memory: word i resets to i, writes land on negedge.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(negedge clock_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  int          passCnt = 0, totalCnt = 0;
  logic [31:0] refMem [16];
  logic        refLast;
  int          expWrites = 0, expReads = 0, seenWrites = 0, seenReads = 0;
  logic [31:0] heldA = 0, heldB = 0;
  logic        altWe [2][32];
  logic [31:0] altAddr [2][32];
  logic [31:0] altWd [2][32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic void refReset();
    for (int i = 0; i < 16; i++) refMem[i] = 32'(i);
    refLast = 1'b1;
  endfunction

  // Reference: accesses applied in grant order against a plain array.
  function automatic void modelAccess(input logic port, input logic we,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.port = port;
    e.err  = (addr >= 32'd16);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we) begin
        refMem[addr[3:0]] = wdata;
        expWrites++;
      end else begin
        e.rdata = refMem[addr[3:0]];
        expReads++;
      end
    end
    expQ.push_back(e);
    refLast = port;
  endfunction

  function automatic logic ackOf(input logic port);
    return port ? b_ack : a_ack;
  endfunction

  function automatic logic [31:0] randAddr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h100;
    return 32'($urandom_range(0, 19));
  endfunction

  task automatic setReq(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
  endtask

  task automatic dropReq(input logic port);
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic waitAck(input logic port, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_in);
      if (ackOf(port)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic doSingle(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int   lat;
    logic inR;
    inR = (addr < 32'd16);
    modelAccess(port, we, addr, wdata);
    @(posedge clock_in); #1;
    setReq(port, we, addr, wdata);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_in);
      if (ackOf(port)) begin
        lat = k;
        break;
      end
      if (k == 2) begin
        chk("mem_read", 32'(mem_read), 32'(!we && inR));
        chk("mem_write", 32'(mem_write), 32'(we && inR));
        if (inR) chk("mem_addr", mem_addr, addr);
        if (inR && we) chk("mem_wdata", mem_wdata, wdata);
        #1 setReq(port, ~we, $urandom, $urandom);
        #1 if (inR) chk("mem_addr_latched", mem_addr, addr);
        chk("mem_write_latched", 32'(mem_write), 32'(we && inR));
      end
    end
    chk("latency", 32'(lat), 32'd3);
    #2 dropReq(port);
  endtask

  task automatic tieThread(input logic port, input int expLat);
    int lat;
    waitAck(port, lat);
    chk(port ? "tie_latency_b" : "tie_latency_a", 32'(lat), 32'(expLat));
    #2 dropReq(port);
  endtask

  task automatic doTie(input logic weA, input logic [31:0] addrA, input logic [31:0] wdA,
                       input logic weB, input logic [31:0] addrB, input logic [31:0] wdB);
    logic w;
    w = ~refLast;
    if (w) begin
      modelAccess(1'b1, weB, addrB, wdB);
      modelAccess(1'b0, weA, addrA, wdA);
    end else begin
      modelAccess(1'b0, weA, addrA, wdA);
      modelAccess(1'b1, weB, addrB, wdB);
    end
    @(posedge clock_in); #1;
    setReq(1'b0, weA, addrA, wdA);
    setReq(1'b1, weB, addrB, wdB);
    fork
      tieThread(1'b0, w ? 5 : 3);
      tieThread(1'b1, w ? 3 : 5);
    join
  endtask

  task automatic altThread(input logic port, input int n, input logic first);
    int lat;
    for (int i = 0; i < n; i++) begin
      @(posedge clock_in); #1;
      setReq(port, altWe[port][i], altAddr[port][i], altWd[port][i]);
      waitAck(port, lat);
      chk(port ? "alt_latency_b" : "alt_latency_a", 32'(lat),
          (i == 0) ? (first ? 32'd3 : 32'd5) : 32'd4);
      #2 dropReq(port);
    end
  endtask

  task automatic doAlt(input int n);
    logic w;
    w = ~refLast;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        altWe[p][i]   = 1'($urandom_range(0, 1));
        altAddr[p][i] = randAddr();
        altWd[p][i]   = $urandom;
      end
    end
    for (int i = 0; i < n; i++) begin
      modelAccess(w, altWe[w][i], altAddr[w][i], altWd[w][i]);
      modelAccess(~w, altWe[~w][i], altAddr[~w][i], altWd[~w][i]);
    end
    fork
      altThread(1'b0, n, w == 1'b0);
      altThread(1'b1, n, w == 1'b1);
    join
  endtask

  // Monitor: pops the scoreboard on every ack and checks per-cycle invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_in);
      if (reset) begin
        heldA = 0;
        heldB = 0;
      end else begin
        chk("a_stall", 32'(a_stall), 32'(a_req & ~a_ack));
        chk("single_ack", 32'(a_ack & b_ack), 32'd0);
        chk("single_strobe", 32'(mem_read & mem_write), 32'd0);
        if (mem_write) seenWrites++;
        if (mem_read) seenReads++;
        if (a_ack || b_ack) begin
          if (expQ.size() == 0) begin
            totalCnt++;
            $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b, required no ack", a_ack, b_ack);
          end else begin
            e = expQ.pop_front();
            chk("ack_port", 32'(b_ack), 32'(e.port));
            if (e.port) begin
              chk("b_rdata", b_rdata, e.rdata);
              chk("b_err", 32'(b_err), 32'(e.err));
              heldB = e.rdata;
            end else begin
              chk("a_rdata", a_rdata, e.rdata);
              chk("a_err", 32'(a_err), 32'(e.err));
              heldA = e.rdata;
            end
          end
        end
        if (!a_ack) chk("a_rdata_held", a_rdata, heldA);
        if (!b_ack) chk("b_rdata_held", b_rdata, heldB);
      end
    end
  end

  initial begin
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    reset = 0;
    refReset();
    #1 reset = 1;
    #2;
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    #9 reset = 0;

    doTie(1'b0, 32'd1, 32'd0, 1'b0, 32'd2, 32'd0);
    doSingle(1'b0, 1'b0, 32'd5, 32'd0);
    doSingle(1'b0, 1'b1, 32'd3, 32'hDEADBEEF);
    doSingle(1'b1, 1'b0, 32'd3, 32'd0);
    doSingle(1'b1, 1'b0, 32'd20, 32'd0);
    doSingle(1'b0, 1'b0, 32'd4, 32'd0);
    for (int i = 0; i < 4; i++)
      doTie(1'($urandom_range(0, 1)), randAddr(), $urandom,
            1'($urandom_range(0, 1)), randAddr(), $urandom);
    for (int i = 0; i < 30; i++)
      doSingle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randAddr(), $urandom);
    doAlt(12);

    // Abandon an A write to word 7 while it is in ACCESS.
    @(posedge clock_in); #1;
    setReq(1'b0, 1'b1, 32'd7, 32'h12345678);
    @(posedge clock_in); #2;
    reset = 1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_a_ack", 32'(a_ack), 32'd0);
    a_req = 0;
    refReset();
    repeat (2) @(posedge clock_in);
    #3 reset = 0;
    repeat (4) @(posedge clock_in);
    doSingle(1'b0, 1'b0, 32'd7, 32'd0);

    repeat (4) @(posedge clock_in);
    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
    chk("write_strobe_cycles", 32'(seenWrites), 32'(expWrites));
    chk("read_strobe_cycles", 32'(seenReads), 32'(expReads));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
